// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron compute node: command codes and the
// decoder / execution-engine state encodings.
package perceptron_pkg;

    localparam logic [7:0] CMD_LOAD_A = 8'd0;
    localparam logic [7:0] CMD_LOAD_B = 8'd1;
    localparam logic [7:0] CMD_OUT    = 8'd2;
    localparam logic [7:0] CMD_CLR    = 8'd3;
    localparam logic [7:0] CMD_MUL    = 8'd5;
    localparam logic [7:0] CMD_MAC    = 8'd6;
    localparam logic [7:0] CMD_DOT    = 8'd7;

    typedef enum logic [1:0] {
        D_ADDR = 2'd0,
        D_CMD  = 2'd1,
        D_PAY  = 2'd2
    } dec_state_e;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_RUN  = 2'd1,
        E_OUT  = 2'd2
    } exec_state_e;

    // True for every command code the node implements.
    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_LOAD_A) || (cmd == CMD_LOAD_B) || (cmd == CMD_OUT) ||
               (cmd == CMD_CLR)    || (cmd == CMD_MUL)    || (cmd == CMD_MAC) ||
               (cmd == CMD_DOT);
    endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Lane-serial multiply + saturating accumulate: sum = min(acc_in + a*b, 2^ACC_W-1).
// Ports: clk, rst (async, active-high), en (capture this cycle's result),
//        a, b (DATA_W operands), acc_in (ACC_W addend),
//        sum (registered result), sat_hit (registered: result was clamped).
module perceptron_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  sum,
    output logic              sat_hit
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    // One spare bit above the wider of product/accumulator so the add never wraps.
    localparam int unsigned FULL_W = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

    logic [FULL_W-1:0] full;
    logic [ACC_W-1:0]  sum_d, sum_q;
    logic              sat_hit_d, sat_hit_q;

    // Exact result, then clamp anything above the ACC_W range to all-ones.
    always_comb begin
        full      = FULL_W'(a) * FULL_W'(b) + FULL_W'(acc_in);
        sat_hit_d = |(full >> ACC_W);
        sum_d     = sat_hit_d ? {ACC_W{1'b1}} : full[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            sat_hit_q <= 1'b0;
        end else if (en) begin
            sum_q     <= sum_d;
            sat_hit_q <= sat_hit_d;
        end
    end

    assign sum     = sum_q;
    assign sat_hit = sat_hit_q;

endmodule

// File: rtl/perceptron_node.sv
// Perceptron compute node on a byte stream. Decodes [addr, cmd, payload] frames,
// holds vectors A, B and result R, runs lane-serial MUL/MAC/DOT with saturation and
// streams R back; frames for other addresses are forwarded on tx.
// Ports: clk, rst (async, active-high); rx_data/rx_valid (unstallable byte strobe);
//        tx_data/tx_valid/tx_ready (holding-register handshake);
//        busy (engine running or OUT pending/streaming), sat (sticky clamp flag),
//        err (1-cycle pulse: timeout, unknown cmd, collision, tx overrun).
module perceptron_node
    import perceptron_pkg::*;
#(
    parameter int unsigned NODE_ADDR   = 100,
    parameter int unsigned LANES       = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       sat,
    output logic       err
);

    localparam int unsigned PAY    = LANES * DATA_W / 8;
    localparam int unsigned RBYTES = LANES * ACC_W / 8;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PCNT_W = (PAY > 1) ? $clog2(PAY) : 1;
    localparam int unsigned BCNT_W = $clog2(RBYTES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned VA_W   = LANES * DATA_W;
    localparam int unsigned VR_W   = LANES * ACC_W;

    dec_state_e          dec_q, dec_d;
    exec_state_e         exec_q, exec_d;
    logic                fwd_q, fwd_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [VA_W-1:0]     pay_q, pay_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic                done_q, done_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [VA_W-1:0]     a_q, a_d, b_q, b_d;
    logic [VR_W-1:0]     r_q, r_d;
    logic [7:0]          op_q, op_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                out_pend_q, out_pend_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                wb_valid_q, wb_valid_d;
    logic [LANE_W-1:0]   wb_lane_q, wb_lane_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                sat_q, sat_d;
    logic                err_q, err_d;

    logic                fwd_byte;
    logic [DATA_W-1:0]   mac_a, mac_b;
    logic [ACC_W-1:0]    mac_acc, mac_sum;
    logic                mac_sat;

    // Operand select for the lane currently in flight. DOT chains through the
    // multiplier's own output register, which holds the previous lane's partial sum.
    always_comb begin
        mac_a   = a_q[int'(lane_q) * DATA_W +: DATA_W];
        mac_b   = b_q[int'(lane_q) * DATA_W +: DATA_W];
        mac_acc = '0;
        if (op_q == CMD_MAC) begin
            mac_acc = r_q[int'(lane_q) * ACC_W +: ACC_W];
        end else if ((op_q == CMD_DOT) && (lane_q != '0)) begin
            mac_acc = mac_sum;
        end
    end

    perceptron_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .en      (exec_q == E_RUN),
        .a       (mac_a),
        .b       (mac_b),
        .acc_in  (mac_acc),
        .sum     (mac_sum),
        .sat_hit (mac_sat)
    );

    // Next-state logic: decoder, timeout, tx holding register, exec engine, commands.
    always_comb begin
        dec_d      = dec_q;
        exec_d     = exec_q;
        fwd_d      = fwd_q;
        cmd_d      = cmd_q;
        pay_d      = pay_q;
        pcnt_d     = pcnt_q;
        done_d     = 1'b0;
        tmo_d      = tmo_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        op_d       = op_q;
        lane_d     = lane_q;
        out_pend_d = out_pend_q;
        bcnt_d     = bcnt_q;
        wb_valid_d = 1'b0;
        wb_lane_d  = wb_lane_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        sat_d      = sat_q;
        err_d      = 1'b0;
        fwd_byte   = 1'b0;

        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        // Frame decoder; an arriving byte always beats a same-cycle timeout.
        if (rx_valid) begin
            tmo_d = '0;
            case (dec_q)
                D_ADDR: begin
                    fwd_d    = (rx_data != 8'(NODE_ADDR));
                    fwd_byte = fwd_d;
                    dec_d    = D_CMD;
                end
                D_CMD: begin
                    cmd_d    = rx_data;
                    pcnt_d   = '0;
                    fwd_byte = fwd_q;
                    dec_d    = D_PAY;
                end
                D_PAY: begin
                    fwd_byte = fwd_q;
                    if (!fwd_q) begin
                        pay_d[int'(pcnt_q) * 8 +: 8] = rx_data;
                    end
                    if (pcnt_q == PCNT_W'(PAY - 1)) begin
                        dec_d  = D_ADDR;
                        done_d = !fwd_q;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end
                default: dec_d = D_ADDR;
            endcase
        end else if (dec_q != D_ADDR) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                dec_d = D_ADDR;
                tmo_d = '0;
                err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        // Forwarded bytes never share the holding register with an OUT stream.
        if (fwd_byte) begin
            if ((exec_q == E_OUT) || (tx_valid_q && !tx_ready)) begin
                err_d = 1'b1;
            end else begin
                tx_valid_d = 1'b1;
                tx_data_d  = rx_data;
            end
        end

        // Writeback of the lane result captured by the multiplier last cycle.
        if (wb_valid_q) begin
            if (mac_sat) begin
                sat_d = 1'b1;
            end
            if (op_q == CMD_DOT) begin
                r_d              = '0;
                r_d[ACC_W-1:0]   = mac_sum;
            end else begin
                r_d[int'(wb_lane_q) * ACC_W +: ACC_W] = mac_sum;
            end
        end

        case (exec_q)
            E_IDLE: begin
                // OUT waits until the holding register is empty and no forward byte lands.
                if (out_pend_q && !tx_valid_q && !fwd_byte) begin
                    exec_d     = E_OUT;
                    out_pend_d = 1'b0;
                    bcnt_d     = '0;
                end
            end
            E_RUN: begin
                wb_valid_d = 1'b1;
                wb_lane_d  = lane_q;
                if (lane_q == LANE_W'(LANES - 1)) begin
                    exec_d = E_IDLE;
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            E_OUT: begin
                if (bcnt_q == BCNT_W'(RBYTES)) begin
                    if (tx_valid_q && tx_ready) begin
                        exec_d = E_IDLE;
                    end
                end else if (!tx_valid_q || tx_ready) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = r_q[int'(bcnt_q) * 8 +: 8];
                    bcnt_d     = bcnt_q + BCNT_W'(1);
                end
            end
            default: exec_d = E_IDLE;
        endcase

        // Command execution, one cycle after the final payload byte.
        if (done_q) begin
            if (!cmd_known(cmd_q)) begin
                err_d = 1'b1;
            end else if ((exec_q != E_IDLE) || out_pend_q || wb_valid_q) begin
                err_d = 1'b1;
            end else begin
                case (cmd_q)
                    CMD_LOAD_A: a_d = pay_q;
                    CMD_LOAD_B: b_d = pay_q;
                    CMD_CLR: begin
                        r_d   = '0;
                        sat_d = 1'b0;
                    end
                    CMD_OUT: out_pend_d = 1'b1;
                    CMD_MUL, CMD_MAC, CMD_DOT: begin
                        exec_d = E_RUN;
                        op_d   = cmd_q;
                        lane_d = '0;
                        if (cmd_q == CMD_MUL) begin
                            sat_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        busy_d = (exec_d != E_IDLE) || out_pend_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q      <= D_ADDR;
            exec_q     <= E_IDLE;
            fwd_q      <= 1'b0;
            cmd_q      <= '0;
            pay_q      <= '0;
            pcnt_q     <= '0;
            done_q     <= 1'b0;
            tmo_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            op_q       <= '0;
            lane_q     <= '0;
            out_pend_q <= 1'b0;
            bcnt_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_lane_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dec_q      <= dec_d;
            exec_q     <= exec_d;
            fwd_q      <= fwd_d;
            cmd_q      <= cmd_d;
            pay_q      <= pay_d;
            pcnt_q     <= pcnt_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            out_pend_q <= out_pend_d;
            bcnt_q     <= bcnt_d;
            wb_valid_q <= wb_valid_d;
            wb_lane_q  <= wb_lane_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            sat_q      <= sat_d;
            err_q      <= err_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign sat      = sat_q;
    assign err      = err_q;

endmodule

// File: tb/tb_perceptron_node.sv
// Bench for perceptron_node: directed scenarios plus randomized frames; tx bytes are
// checked by a scoreboard fed from a plain-arithmetic vector model.
module tb_perceptron_node;

    localparam int unsigned NODE_ADDR   = 100;
    localparam int unsigned LANES       = 4;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ACC_W       = 16;
    localparam int unsigned TIMEOUT_CYC = 300;
    localparam int unsigned PAY         = LANES * DATA_W / 8;
    localparam int unsigned RB          = ACC_W / 8;
    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       sat;
    logic       err;

    perceptron_node #(
        .NODE_ADDR   (NODE_ADDR),
        .LANES       (LANES),
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .sat      (sat),
        .err      (err)
    );

    int errors   = 0;
    int checks   = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;
    int mon_cnt  = 0;
    int cyc      = 0;
    bit ready_mode = 1'b0;

    logic [7:0]      exp_q[$];
    logic [7:0]      mon_exp;
    longint unsigned ma[LANES];
    longint unsigned mb[LANES];
    longint unsigned mr[LANES];
    bit              msat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // tx_ready: always high, or high one cycle in three.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tx_ready = (!ready_mode) || ((cyc % 3) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: pulse counters and scoreboard on every tx handshake.
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (busy) busy_cnt++;
        if (!rst && tx_valid && tx_ready) begin
            mon_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %0d expected no byte", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_byte", longint'(tx_data), longint'(mon_exp));
            end
        end
    end

    function automatic longint unsigned clamp(input longint unsigned v, inout bit s);
        if (v > ACC_MAX) begin
            s = 1'b1;
            return ACC_MAX;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            ma[i] = 0;
            mb[i] = 0;
            mr[i] = 0;
        end
        msat = 1'b0;
    endtask

    // Reference behaviour of one addressed frame.
    task automatic model_cmd(input logic [7:0] cmd, input logic [PAY*8-1:0] pay);
        longint unsigned s;
        case (cmd)
            8'd0: for (int i = 0; i < LANES; i++) ma[i] = longint'(pay[i*8 +: 8]);
            8'd1: for (int i = 0; i < LANES; i++) mb[i] = longint'(pay[i*8 +: 8]);
            8'd3: begin
                for (int i = 0; i < LANES; i++) mr[i] = 0;
                msat = 1'b0;
            end
            8'd5: begin
                msat = 1'b0;
                for (int i = 0; i < LANES; i++) mr[i] = clamp(ma[i] * mb[i], msat);
            end
            8'd6: for (int i = 0; i < LANES; i++) mr[i] = clamp(mr[i] + ma[i] * mb[i], msat);
            8'd7: begin
                s = 0;
                for (int i = 0; i < LANES; i++) s += ma[i] * mb[i];
                for (int i = 0; i < LANES; i++) mr[i] = 0;
                mr[0] = clamp(s, msat);
            end
            8'd2: begin
                for (int i = 0; i < LANES; i++)
                    for (int k = 0; k < RB; k++)
                        exp_q.push_back(8'((mr[i] >> (8 * k)) & 64'hFF));
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] cmd,
                              input logic [PAY*8-1:0] pay, input int gap_max);
        if (addr == 8'(NODE_ADDR)) begin
            model_cmd(cmd, pay);
        end else begin
            exp_q.push_back(addr);
            exp_q.push_back(cmd);
            for (int k = 0; k < PAY; k++) exp_q.push_back(pay[k*8 +: 8]);
        end
        send_byte(addr, $urandom_range(0, gap_max));
        send_byte(cmd, $urandom_range(0, gap_max));
        for (int k = 0; k < PAY; k++) send_byte(pay[k*8 +: 8], $urandom_range(0, gap_max));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (3) tick();
        while ((busy || tx_valid || (exp_q.size() != 0)) && (n < 3000)) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%0d queued=%0d expected idle", busy, exp_q.size());
        end
        repeat (2) tick();
    endtask

    localparam logic [31:0] VEC_A = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] VEC_B = {8'd40, 8'd30, 8'd20, 8'd10};

    initial begin
        int b0;
        int e0;
        int m0;
        int n;
        int op;
        logic [7:0] addr;
        logic [PAY*8-1:0] pay;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        model_reset();
        repeat (3) tick();
        check("reset_tx_valid", tx_valid, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_busy", busy, 0);
        check("reset_sat", sat, 0);
        check("reset_err", err, 0);
        rst = 1'b0;
        tick();

        // 1: load, multiply, stream.
        send_frame(8'd100, 8'd0, VEC_A, 2);
        send_frame(8'd100, 8'd1, VEC_B, 2);
        wait_idle();
        send_frame(8'd100, 8'd5, 32'd0, 2);
        wait_idle();
        send_frame(8'd100, 8'd2, 32'd0, 2);
        wait_idle();
        check("t1_sat", sat, msat);

        // 2: accumulate; engine busy exactly one cycle per lane.
        b0 = busy_cnt;
        send_frame(8'd100, 8'd6, 32'd0, 2);
        wait_idle();
        check("t2_mac_busy_cycles", longint'(busy_cnt - b0), LANES);
        send_frame(8'd100, 8'd2, 32'd0, 2);
        wait_idle();

        // 3: foreign-address frame forwarded, state untouched.
        send_frame(8'd101, 8'd5, 32'd0, 0);
        wait_idle();
        send_frame(8'd100, 8'd2, 32'd0, 2);
        wait_idle();

        // 4: saturation, clear, dot product.
        send_frame(8'd100, 8'd0, 32'hFFFF_FFFF, 1);
        send_frame(8'd100, 8'd1, 32'hFFFF_FFFF, 1);
        wait_idle();
        send_frame(8'd100, 8'd5, 32'd0, 1);
        wait_idle();
        send_frame(8'd100, 8'd6, 32'd0, 1);
        wait_idle();
        check("t4_sat_set", sat, 1);
        send_frame(8'd100, 8'd2, 32'd0, 1);
        wait_idle();
        send_frame(8'd100, 8'd3, 32'd0, 1);
        wait_idle();
        check("t4_sat_cleared", sat, 0);
        send_frame(8'd100, 8'd0, VEC_A, 1);
        send_frame(8'd100, 8'd1, VEC_B, 1);
        wait_idle();
        send_frame(8'd100, 8'd7, 32'd0, 1);
        wait_idle();
        send_frame(8'd100, 8'd2, 32'd0, 1);
        wait_idle();

        // 5: partial frame times out once; decoding recovers; unknown command rejected.
        e0 = err_cnt;
        send_byte(8'd100, 0);
        send_byte(8'd1, 0);
        send_byte(8'd7, 0);
        send_byte(8'd7, 0);
        repeat (TIMEOUT_CYC - 2) tick();
        check("t5_no_early_timeout", longint'(err_cnt - e0), 0);
        repeat (3) tick();
        check("t5_timeout_err", longint'(err_cnt - e0), 1);
        send_frame(8'd100, 8'd1, {8'd8, 8'd7, 8'd6, 8'd5}, 2);
        wait_idle();
        send_frame(8'd100, 8'd5, 32'd0, 2);
        wait_idle();
        send_frame(8'd100, 8'd2, 32'd0, 2);
        wait_idle();
        e0 = err_cnt;
        send_frame(8'd100, 8'd9, 32'h1234_5678, 2);
        wait_idle();
        check("t5_bad_cmd_err", longint'(err_cnt - e0), 1);
        send_frame(8'd100, 8'd2, 32'd0, 2);
        wait_idle();

        // 6: throttled OUT, reset after the third byte.
        ready_mode = 1'b1;
        m0 = mon_cnt;
        send_frame(8'd100, 8'd2, 32'd0, 0);
        n = 0;
        while ((mon_cnt < m0 + 3) && (n < 500)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t6_three_bytes_seen", longint'(mon_cnt - m0 >= 3), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_tx_valid", tx_valid, 0);
        check("t6_rst_busy", busy, 0);
        exp_q.delete();
        model_reset();
        ready_mode = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("t6_post_rst_sat", sat, 0);
        send_frame(8'd100, 8'd2, 32'd0, 2);
        wait_idle();

        // Randomized frames against the model.
        for (int it = 0; it < 40; it++) begin
            op  = $urandom_range(0, 7);
            pay = $urandom();
            if ($urandom_range(0, 1) == 1) pay = pay | 32'hC0C0_C0C0;
            case (op)
                0: send_frame(8'd100, 8'd0, pay, 2);
                1: send_frame(8'd100, 8'd1, pay, 2);
                2: send_frame(8'd100, 8'd5, pay, 2);
                3: send_frame(8'd100, 8'd6, pay, 2);
                4: send_frame(8'd100, 8'd7, pay, 2);
                5: send_frame(8'd100, 8'd3, pay, 2);
                6: send_frame(8'd100, 8'd2, pay, 2);
                default: begin
                    addr = 8'($urandom_range(0, 254));
                    if (addr >= 8'd100) addr = addr + 8'd1;
                    send_frame(addr, 8'($urandom_range(0, 255)), pay, 2);
                end
            endcase
            wait_idle();
            check("rand_sat", sat, msat);
        end
        send_frame(8'd100, 8'd2, 32'd0, 2);
        wait_idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
